blit_scheduler: RTL

- Upstream stage of copy_engine. Buffers sprite-draw commands in a FIFO and replays them to copy_engine once per frame.
- Drives copy_engine's dest window, src_addr_start and execute; watches its status.
- Game logic pushes commands at any time. Drawing starts on the rising edge of frame_clk (VGA vertical sync).

---
 rtl/blit_pkg.sv | 24 ++
 rtl/blit_cmd_fifo.sv | 57 +++++
 rtl/blit_scheduler.sv | 124 ++++++++++++
 3 files changed

// File: rtl/blit_pkg.sv
// rtl/blit_pkg.sv - shared types and screen constants for the blit scheduler
package blit_pkg;

  localparam int SRC_W    = 14;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef struct packed {
    logic [9:0]       x;
    logic [9:0]       y;
    logic [9:0]       w;
    logic [9:0]       h;
    logic [SRC_W-1:0] src;
  } draw_cmd_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    EXEC = 3'd2,
    REL  = 3'd3,
    NEXT = 3'd4
  } sched_state_t;

endpackage

// File: rtl/blit_cmd_fifo.sv
// rtl/blit_cmd_fifo.sv - synchronous draw-command FIFO with registered read port
module blit_cmd_fifo
  import blit_pkg::*;
#(
  parameter int Depth = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  draw_cmd_t                  push_data,
  input  logic                       pop,
  output draw_cmd_t                  pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(Depth):0]     count
);

  localparam int AW = $clog2(Depth);
  localparam int CW = AW + 1;

  draw_cmd_t       mem [Depth];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push_ok;
  logic            pop_ok;

  assign full    = (count == CW'(Depth));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pop_data <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok) begin
        rd_ptr   <= rd_ptr + AW'(1);
        pop_data <= mem[rd_ptr];
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/blit_scheduler.sv
// rtl/blit_scheduler.sv - per-frame replay of queued sprite draws to copy_engine (option: BLIT_SCHED_CLIP_EN)
module blit_scheduler
  import blit_pkg::*;
#(
  parameter int SrcAddrWidth = 14,
  parameter int FifoDepth    = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          frame_clk,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [9:0]                    cmd_x,
  input  logic [9:0]                    cmd_y,
  input  logic [9:0]                    cmd_w,
  input  logic [9:0]                    cmd_h,
  input  logic [SrcAddrWidth-1:0]       cmd_src,
  output logic [9:0]                    dest_x_start,
  output logic [9:0]                    dest_x_end,
  output logic [9:0]                    dest_y_start,
  output logic [9:0]                    dest_y_end,
  output logic [SrcAddrWidth-1:0]       src_addr_start,
  output logic                          execute,
  input  logic                          status,
  output logic                          busy,
  output logic                          overrun,
  output logic [$clog2(FifoDepth):0]    fifo_count
);

  logic         frame_q1;
  logic         frame_q2;
  logic         start;
  sched_state_t state;
  draw_cmd_t    push_cmd;
  draw_cmd_t    head;
  logic         fifo_pop;
  logic         fifo_full;
  logic         fifo_empty;
  logic [9:0]   x_end;
  logic [9:0]   y_end;
  logic         discard;

  assign push_cmd = '{x: cmd_x, y: cmd_y, w: cmd_w, h: cmd_h, src: SRC_W'(cmd_src)};

  blit_cmd_fifo #(.Depth(FifoDepth)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (cmd_valid),
    .push_data (push_cmd),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign start     = frame_q1 & ~frame_q2;
  assign cmd_ready = ~fifo_full;
  assign busy      = (state != IDLE);

`ifdef BLIT_SCHED_CLIP_EN
  logic [10:0] x_sum;
  logic [10:0] y_sum;
  assign x_sum   = {1'b0, head.x} + {1'b0, head.w};
  assign y_sum   = {1'b0, head.y} + {1'b0, head.h};
  assign x_end   = (x_sum > 11'(SCREEN_W)) ? 10'(SCREEN_W) : x_sum[9:0];
  assign y_end   = (y_sum > 11'(SCREEN_H)) ? 10'(SCREEN_H) : y_sum[9:0];
  assign discard = (head.w == '0) || (head.h == '0) ||
                   (head.x >= 10'(SCREEN_W)) || (head.y >= 10'(SCREEN_H));
`else
  assign x_end   = head.x + head.w;
  assign y_end   = head.y + head.h;
  assign discard = (head.w == '0) || (head.h == '0);
`endif

  // The FIFO read is registered, so the pop is issued on the way into LOAD.
  always_comb begin
    fifo_pop = 1'b0;
    if (!fifo_empty && ((state == IDLE && start) || state == NEXT)) fifo_pop = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_q1       <= 1'b0;
      frame_q2       <= 1'b0;
      state          <= IDLE;
      overrun        <= 1'b0;
      execute        <= 1'b0;
      dest_x_start   <= '0;
      dest_x_end     <= '0;
      dest_y_start   <= '0;
      dest_y_end     <= '0;
      src_addr_start <= '0;
    end else begin
      frame_q1 <= frame_clk;
      frame_q2 <= frame_q1;
      if (start && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (start && !fifo_empty) state <= LOAD;
        LOAD: begin
          dest_x_start   <= head.x;
          dest_x_end     <= x_end;
          dest_y_start   <= head.y;
          dest_y_end     <= y_end;
          src_addr_start <= SrcAddrWidth'(head.src);
          state          <= discard ? NEXT : EXEC;
        end
        // execute only rises once the engine reports idle, keeping the handshake four-phase
        EXEC: begin
          if (execute && status) begin
            execute <= 1'b0;
            state   <= REL;
          end else if (!status) begin
            execute <= 1'b1;
          end
        end
        REL:  if (!status) state <= NEXT;
        NEXT: state <= fifo_empty ? IDLE : LOAD;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
